// File: rtl/rattlesnake_fetch_pkg.sv
// Shared defaults for the rattlesnake prefetching fetch unit.
// Imported by the fetch queue top level and its FIFO.
package rattlesnake_fetch_pkg;

  localparam int DEF_PC_BITWIDTH     = 32;
  localparam int DEF_XLEN            = 32;
  localparam int DEF_MEM_ADDR_BITS   = 16;
  localparam int DEF_QUEUE_DEPTH     = 4;
  localparam int DEF_MAX_OUTSTANDING = 2;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/rattlesnake_fetch_fifo.sv
// Flop-based synchronous FIFO holding {PC, IR} pairs for the fetch queue.
// Flush empties it in one cycle; the head entry is always visible on head_o.
module rattlesnake_fetch_fifo
  import rattlesnake_fetch_pkg::*;
#(
  parameter int WIDTH = DEF_PC_BITWIDTH + DEF_XLEN,
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [LVL_W-1:0] level_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset here because the head slot drives PC_out/IR_out,
      // which must read zero after reset; a deeper RAM-style buffer would skip this.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      rd_q    <= wr_q;
      level_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push_i) - LVL_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/rattlesnake_fetch_prefetch_queue.sv
// Prefetching instruction fetch unit: keeps in-order reads in flight, buffers the
// returned words in a small queue, and drops stale responses after a redirect.
module rattlesnake_fetch_prefetch_queue
  import rattlesnake_fetch_pkg::*;
#(
  parameter int PC_BITWIDTH     = DEF_PC_BITWIDTH,
  parameter int XLEN            = DEF_XLEN,
  parameter int MEM_ADDR_BITS   = DEF_MEM_ADDR_BITS,
  parameter int QUEUE_DEPTH     = DEF_QUEUE_DEPTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sync_reset,
  input  logic                           fetch_init,
  input  logic [PC_BITWIDTH-1:0]         start_addr,
  input  logic                           fetch_next,
  output logic                           fetch_enable_out,
  output logic [XLEN-1:0]                IR_out,
  output logic [PC_BITWIDTH-1:0]         PC_out,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
  output logic                           fetch_error,
  output logic                           read_mem_enable,
  output logic [PC_BITWIDTH-1:0]         read_mem_addr,
  input  logic                           mem_read_done,
  input  logic [XLEN-1:0]                mem_data,
  input  logic [MEM_ADDR_BITS-1:0]       mem_addr_ack
);

  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int OCC_W = LVL_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         inflight_q, inflight_d;
  logic [CNT_W-1:0]         drop_q;
  logic [CNT_W-1:0]         live;
  logic [OCC_W-1:0]         occupancy;
  logic [PC_BITWIDTH-1:0]   issue_pc_q, resp_pc_q;
  logic [PC_BITWIDTH+XLEN-1:0] head;
  logic flush, issue, pop;
  logic resp_valid, resp_stray, resp_drop, resp_write, addr_bad;

  assign flush = fetch_init | sync_reset;

  // Reads already owed to a dead redirect do not count against queue space.
  assign live      = inflight_q - drop_q;
  assign occupancy = OCC_W'(queue_level) + OCC_W'(live);

  assign issue = (state_q == ST_RUN) && !flush
              && (inflight_q < CNT_W'(MAX_OUTSTANDING))
              && (occupancy < OCC_W'(QUEUE_DEPTH));

  assign resp_valid = mem_read_done && (inflight_q != '0);
  assign resp_stray = mem_read_done && (inflight_q == '0);
  assign resp_drop  = resp_valid && (drop_q != '0);
  assign resp_write = resp_valid && !flush && (drop_q == '0);
  assign addr_bad   = mem_addr_ack != resp_pc_q[MEM_ADDR_BITS+1:2];

  assign pop = fetch_next && (queue_level != '0) && !flush;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    inflight_d = inflight_q;
    if (issue)      inflight_d = inflight_d + CNT_W'(1);
    if (resp_valid) inflight_d = inflight_d - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      inflight_q  <= '0;
      drop_q      <= '0;
      issue_pc_q  <= '0;
      resp_pc_q   <= '0;
      fetch_error <= 1'b0;
    end else begin
      if (sync_reset)      state_q <= ST_IDLE;
      else if (fetch_init) state_q <= ST_RUN;

      inflight_q <= inflight_d;

      if (flush) begin
        drop_q     <= inflight_q - CNT_W'(resp_valid);
        issue_pc_q <= sync_reset ? '0 : start_addr;
        resp_pc_q  <= sync_reset ? '0 : start_addr;
      end else begin
        if (issue)      issue_pc_q <= issue_pc_q + PC_BITWIDTH'(PC_STEP);
        if (resp_drop)  drop_q     <= drop_q - CNT_W'(1);
        if (resp_write) resp_pc_q  <= resp_pc_q + PC_BITWIDTH'(PC_STEP);
      end

      if (sync_reset)                               fetch_error <= 1'b0;
      else if (resp_stray || (resp_write && addr_bad)) fetch_error <= 1'b1;
    end
  end

  rattlesnake_fetch_fifo #(
    .WIDTH (PC_BITWIDTH + XLEN),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .push_i  (resp_write),
    .pop_i   (pop),
    .data_i  ({resp_pc_q, mem_data}),
    .head_o  (head),
    .level_o (queue_level)
  );

  assign {PC_out, IR_out}  = head;
  assign fetch_enable_out  = (queue_level != '0);
  assign read_mem_enable   = issue;
  assign read_mem_addr     = issue_pc_q;

endmodule
